zcip_scheduler: RTL and testbench
=================================

ZCIP_SCHEDULER -- requirements
Module: zcip_scheduler

Interface
REQ-001 SHALL have parameter LANES, default 4, number of BCE lanes fed.
REQ-002 SHALL have parameter NW, default 8, weights per lane; also the width of the emitted bit-column.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-005 SHALL have port in_weights, input, LANES*NW*8, weight group, sign-magnitude 8-bit, bit7 = sign; lane i = bits [i*64+63:i*64]; weight j of a lane = bits [j*8+7:j*8] within the lane.
REQ-006 SHALL have port in_valid, input, 1, in_weights is valid.
REQ-007 SHALL have port in_ready, output, 1, block can accept a group.
REQ-008 SHALL have port out_ready, input, 1, downstream PE accepts the current beat.
REQ-009 SHALL have port weight_column, output, LANES*NW, one bit-column per lane; bit j = chosen bit of weight j.
REQ-010 SHALL have port weight_sign_en, output, 1, current beat is the sign column.
REQ-011 SHALL have port weight_valid, output, 1, beat valid.
REQ-012 SHALL have port shift_offset, output, LANES*3, per-lane bit index of the column.
REQ-013 SHALL have port zcip_done, output, LANES, lane has no magnitude column left to send.
REQ-014 SHALL have port group_last, output, 1, current beat is the final beat of the group.

Function
REQ-015 SHALL implement states IDLE, SIGN, SCAN.
REQ-016 IDLE: in_ready=1, weight_valid=0; on in_valid register in_weights and per-lane 7-bit magnitude masks.
- Mask bit k set iff any weight of the lane has magnitude bit k = 1.
- Next state SIGN; first beat is visible the cycle after acceptance.
REQ-017 SIGN beat contents: weight_valid=1, weight_sign_en=1, per lane column = bit7 of each weight, shift_offset=7.
REQ-018 SIGN transitions on out_ready: to SCAN if any mask is nonzero, else to IDLE with group_last=1 on this beat.
REQ-019 SCAN lane selection: each lane independently selects the highest set mask bit k.
- Outputs column = bit k of each weight, shift_offset=k, weight_sign_en=0, weight_valid=1.
REQ-020 SCAN handshake (weight_valid & out_ready) clears the selected bit in every non-empty lane.
REQ-021 Empty lane in SCAN: column=0, shift_offset=0, zcip_done[i]=1.
- zcip_done[i] is combinational from mask==0 and is also valid during the SIGN beat.
REQ-022 group_last=1 in SCAN when every lane mask has at most one bit set; the handshake on that beat returns to IDLE.
REQ-023 Without out_ready all outputs and state SHALL hold stable, with no change of beat contents while stalled.
REQ-024 in_ready SHALL be 0 outside IDLE; a group is never overwritten mid-scan.
REQ-025 Beats per group SHALL equal 1 + max over lanes of popcount(mask).
REQ-026 All-zero-magnitude group (signs arbitrary) SHALL produce exactly one SIGN beat with group_last=1 and zcip_done all 1s.
REQ-027 Outputs in IDLE: weight_column=0, shift_offset=0, weight_sign_en=0, group_last=0, zcip_done=all 1s.

Reset
REQ-028 rst SHALL asynchronously force IDLE, clear registered weights and masks, and drive the outputs listed in REQ-027, with in_ready=1 after release.
REQ-029 rst asserted mid-group SHALL discard the group; no further beats of it are emitted.

Verification
REQ-030 Bench SHALL cover the following scenarios:
- Lane0 weights all 0x05, others 0x00, out_ready=1 -> beats: SIGN; lane0 k=2 (col 0xFF); lane0 k=0 (col 0xFF, group_last=1). zcip_done=4'b1110 throughout; 3 beats total.
- All weights 0x80 -> single SIGN beat, each lane col 0xFF, shift 7, group_last=1, zcip_done=4'hF; next cycle in_ready=1.
- Lane3 weight0=0x7F, others zero -> SIGN then 7 beats, shift 6..0 on lane3, col 0x01; lanes 0-2 done.
- out_ready toggled 1,0,0,1 on the second beat -> beat held unchanged for 2 stall cycles, no beat dropped or duplicated.
- rst pulsed during the 2nd SCAN beat -> immediate IDLE outputs; next group accepted starts with a SIGN beat.
- in_valid held high while busy -> in_ready=0 and the group is not captured until IDLE.

Source files
------------

// File: rtl/zcip_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : zcip_scheduler
// Purpose  : Zero-column-skipping weight scheduler. Accepts a group of
//            sign-magnitude 8-bit weights for LANES lanes. It first emits
//            one sign-column beat. It then emits one beat per magnitude
//            bit-column, taking the highest set column first. Magnitude
//            columns that are all zero in a lane are skipped.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            in   1            clock, rising edge
//   rst            in   1            asynchronous active-high reset
//   in_weights     in   LANES*NW*8   weight group (lane i, weight j at
//                                    [i*NW*8 + j*8 +: 8])
//   in_valid       in   1            in_weights valid
//   in_ready       out  1            idle, a group can be accepted
//   out_ready      in   1            downstream accepts the current beat
//   weight_column  out  LANES*NW     per-lane bit-column (bit j = weight j)
//   weight_sign_en out  1            current beat is the sign column
//   weight_valid   out  1            beat valid
//   shift_offset   out  LANES*3      per-lane bit index of the column
//   zcip_done      out  LANES        lane has no magnitude column left
//   group_last     out  1            current beat ends the group
// ============================================================================
module zcip_scheduler #(
  parameter int LANES = 4,
  parameter int NW    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES*NW*8-1:0] in_weights,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  out_ready,
  output logic [LANES*NW-1:0]   weight_column,
  output logic                  weight_sign_en,
  output logic                  weight_valid,
  output logic [LANES*3-1:0]    shift_offset,
  output logic [LANES-1:0]      zcip_done,
  output logic                  group_last
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SIGN = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic [LANES*NW*8-1:0]   r_weights;
  logic [LANES*7-1:0]      r_mask;
  logic [LANES*7-1:0]      w_mask_in;
  logic [LANES*7-1:0]      w_mask_clr;
  logic [LANES*3-1:0]      w_sel;
  logic [LANES-1:0]        w_empty;
  logic [LANES-1:0]        w_multi;
  logic [LANES*NW-1:0]     w_sign_col;
  logic [LANES*NW-1:0]     w_scan_col;
  logic                    w_load;
  logic                    w_advance;

  // Per-lane datapath: mask build, highest-bit select, column extraction.
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [6:0]    w_mi;
    logic [6:0]    w_m;
    logic [2:0]    w_k;
    logic [NW-1:0] w_sg;
    logic [NW-1:0] w_sc;

    // Mask bit k is the OR of magnitude bit k over every weight of the lane.
    always_comb begin
      w_mi = 7'd0;
      for (int j = 0; j < NW; j++) begin
        for (int k = 0; k < 7; k++) begin
          w_mi[k] = w_mi[k] | in_weights[i*NW*8 + j*8 + k];
        end
      end
    end

    assign w_m = r_mask[i*7 +: 7];

    // Ascending scan so the last hit, i.e. the highest set bit, wins.
    always_comb begin
      w_k = 3'd0;
      for (int k = 0; k < 7; k++) begin
        if (w_m[k]) w_k = k[2:0];
      end
    end

    always_comb begin
      w_sg = '0;
      w_sc = '0;
      for (int j = 0; j < NW; j++) begin
        w_sg[j] = r_weights[i*NW*8 + j*8 + 7];
        w_sc[j] = (w_m != 7'd0) ? r_weights[i*NW*8 + j*8 + int'(w_k)] : 1'b0;
      end
    end

    assign w_mask_in[i*7 +: 7]   = w_mi;
    assign w_mask_clr[i*7 +: 7]  = w_m & ~(7'd1 << w_k);
    assign w_sel[i*3 +: 3]       = w_k;
    assign w_empty[i]            = (w_m == 7'd0);
    // More than one bit set: clearing the lowest set bit leaves something.
    assign w_multi[i]            = |(w_m & (w_m - 7'd1));
    assign w_sign_col[i*NW +: NW] = w_sg;
    assign w_scan_col[i*NW +: NW] = w_sc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next         = r_state;
    w_load         = 1'b0;
    w_advance      = 1'b0;
    in_ready       = 1'b0;
    weight_valid   = 1'b0;
    weight_sign_en = 1'b0;
    weight_column  = '0;
    shift_offset   = '0;
    group_last     = 1'b0;
    zcip_done      = w_empty;
    case (r_state)
      ST_IDLE: begin
        in_ready  = 1'b1;
        zcip_done = '1;
        if (in_valid) begin
          w_load = 1'b1;
          w_next = ST_SIGN;
        end
      end
      ST_SIGN: begin
        weight_valid   = 1'b1;
        weight_sign_en = 1'b1;
        weight_column  = w_sign_col;
        shift_offset   = {LANES{3'd7}};
        group_last     = &w_empty;
        if (out_ready) begin
          w_next = (&w_empty) ? ST_IDLE : ST_SCAN;
        end
      end
      ST_SCAN: begin
        weight_valid  = 1'b1;
        weight_column = w_scan_col;
        shift_offset  = w_sel;
        group_last    = ~|w_multi;
        if (out_ready) begin
          w_advance = 1'b1;
          if (~|w_multi) w_next = ST_IDLE;
        end
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_weights <= '0;
      r_mask    <= '0;
    end else if (w_load) begin
      r_weights <= in_weights;
      r_mask    <= w_mask_in;
    end else if (w_advance) begin
      r_mask    <= w_mask_clr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_zcip_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_zcip_scheduler
// Purpose  : Directed self-checking bench for zcip_scheduler (LANES=4, NW=8).
//            Expected beats are hand-computed from the weight patterns.
// Revision : 1.0 - initial release
// ============================================================================
module tb_zcip_scheduler;
  localparam int LANES = 4;
  localparam int NW    = 8;

  logic                  clk;
  logic                  rst;
  logic [LANES*NW*8-1:0] in_weights;
  logic                  in_valid;
  logic                  in_ready;
  logic                  out_ready;
  logic [LANES*NW-1:0]   weight_column;
  logic                  weight_sign_en;
  logic                  weight_valid;
  logic [LANES*3-1:0]    shift_offset;
  logic [LANES-1:0]      zcip_done;
  logic                  group_last;

  int n_checks;
  int n_errors;

  logic [LANES*NW*8-1:0] c_w1;   // lane0 all 0x05
  logic [LANES*NW*8-1:0] c_w80;  // all 0x80
  logic [LANES*NW*8-1:0] c_w3;   // lane3 weight0 0x7F

  zcip_scheduler #(.LANES(LANES), .NW(NW)) u_dut (
    .clk            (clk),
    .rst            (rst),
    .in_weights     (in_weights),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .out_ready      (out_ready),
    .weight_column  (weight_column),
    .weight_sign_en (weight_sign_en),
    .weight_valid   (weight_valid),
    .shift_offset   (shift_offset),
    .zcip_done      (zcip_done),
    .group_last     (group_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_chk(input string tag);
    check({tag, ".in_ready"}, in_ready, 1);
    check({tag, ".valid"}, weight_valid, 0);
    check({tag, ".col"}, weight_column, 0);
    check({tag, ".shift"}, shift_offset, 0);
    check({tag, ".sign"}, weight_sign_en, 0);
    check({tag, ".last"}, group_last, 0);
    check({tag, ".done"}, zcip_done, 4'hF);
  endtask

  task automatic beat(input string tag, input logic [31:0] col, input logic [11:0] sh,
                      input logic sg, input logic last, input logic [3:0] done);
    check({tag, ".valid"}, weight_valid, 1);
    check({tag, ".in_ready"}, in_ready, 0);
    check({tag, ".col"}, weight_column, col);
    check({tag, ".shift"}, shift_offset, sh);
    check({tag, ".sign"}, weight_sign_en, sg);
    check({tag, ".last"}, group_last, last);
    check({tag, ".done"}, zcip_done, done);
  endtask

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    c_w1       = {192'h0, {8{8'h05}}};
    c_w80      = {32{8'h80}};
    c_w3       = '0;
    c_w3[199:192] = 8'h7F;

    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_weights = '0;
    @(negedge clk);
    @(negedge clk);
    idle_chk("reset");
    rst = 1'b0;
    @(negedge clk);
    idle_chk("post_reset");

    // Lane0 all 0x05: SIGN, k=2, k=0.
    in_weights = c_w1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    beat("s1_sign", 32'h0, 12'hFFF, 1, 0, 4'hE);
    @(negedge clk); beat("s1_k2", 32'hFF, 12'h002, 0, 0, 4'hE);
    @(negedge clk); beat("s1_k0", 32'hFF, 12'h000, 0, 1, 4'hE);
    @(negedge clk); idle_chk("s1_end");

    // All 0x80: single SIGN beat.
    in_weights = c_w80; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    beat("s2_sign", 32'hFFFFFFFF, 12'hFFF, 1, 1, 4'hF);
    @(negedge clk); idle_chk("s2_end");

    // Lane3 weight0 0x7F: SIGN then k=6..0.
    in_weights = c_w3; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    beat("s3_sign", 32'h0, 12'hFFF, 1, 0, 4'h7);
    for (int k = 6; k >= 0; k--) begin
      @(negedge clk);
      beat($sformatf("s3_k%0d", k), 32'h01000000, 12'(k) << 9, 0, (k == 0), 4'h7);
    end
    @(negedge clk); idle_chk("s3_end");

    // Stall: out_ready 1,0,0,1 across the second beat.
    in_weights = c_w1; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    beat("s4_sign", 32'h0, 12'hFFF, 1, 0, 4'hE);
    @(negedge clk); out_ready = 1'b0;
    beat("s4_k2", 32'hFF, 12'h002, 0, 0, 4'hE);
    @(negedge clk); beat("s4_stall1", 32'hFF, 12'h002, 0, 0, 4'hE);
    @(negedge clk); out_ready = 1'b1;
    beat("s4_stall2", 32'hFF, 12'h002, 0, 0, 4'hE);
    @(negedge clk); beat("s4_k0", 32'hFF, 12'h000, 0, 1, 4'hE);
    @(negedge clk); idle_chk("s4_end");

    // Reset during the second SCAN beat.
    in_weights = c_w3; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    beat("s5_sign", 32'h0, 12'hFFF, 1, 0, 4'h7);
    @(negedge clk); beat("s5_k6", 32'h01000000, 12'(6) << 9, 0, 0, 4'h7);
    @(negedge clk); beat("s5_k5", 32'h01000000, 12'(5) << 9, 0, 0, 4'h7);
    rst = 1'b1;
    #1;
    idle_chk("s5_rst");
    @(negedge clk); rst = 1'b0;
    idle_chk("s5_rst_hold");
    in_weights = c_w1; in_valid = 1'b1;
    @(negedge clk); in_valid = 1'b0;
    beat("s5_new_sign", 32'h0, 12'hFFF, 1, 0, 4'hE);
    @(negedge clk); beat("s5_new_k2", 32'hFF, 12'h002, 0, 0, 4'hE);
    @(negedge clk); beat("s5_new_k0", 32'hFF, 12'h000, 0, 1, 4'hE);
    @(negedge clk); idle_chk("s5_end");

    // in_valid held high while busy with changing weights.
    in_weights = c_w3; in_valid = 1'b1;
    @(negedge clk); in_weights = c_w80;
    beat("s6_sign", 32'h0, 12'hFFF, 1, 0, 4'h7);
    for (int k = 6; k >= 0; k--) begin
      @(negedge clk);
      beat($sformatf("s6_k%0d", k), 32'h01000000, 12'(k) << 9, 0, (k == 0), 4'h7);
    end
    @(negedge clk);
    check("s6_idle.in_ready", in_ready, 1);
    check("s6_idle.valid", weight_valid, 0);
    @(negedge clk); in_valid = 1'b0;
    beat("s6_next_sign", 32'hFFFFFFFF, 12'hFFF, 1, 1, 4'hF);
    @(negedge clk); idle_chk("s6_end");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
